// File: rtl/fd_pkg.sv
// Definitions shared by the fractional-divider generator and the period meter.
package fd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } pm_state_e;

    localparam int CNT_W_DEF = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

    // Base division count of the generator; the meter sees base+1 (+m) periods.
    localparam int DIV_BASE = 1000;

endpackage

// File: rtl/pm_edge_detect.sv
// Samples sig_in and produces single-cycle rise/fall strobes from two registered taps.
// Define PERIOD_METER_SYNC_EN to put a 2-flop synchronizer ahead of the sample register.
module pm_edge_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sig_src;
    logic sig_s_q, sig_s_d;
    logic sig_d_q, sig_d_d;

`ifdef PERIOD_METER_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], sig_in};
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sig_src = sync_q[1];
`else
    assign sig_src = sig_in;
`endif

    always_comb begin
        sig_s_d = sig_src;
        sig_d_d = sig_s_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sig_s_q <= 1'b0;
            sig_d_q <= 1'b0;
        end else begin
            sig_s_q <= sig_s_d;
            sig_d_q <= sig_d_d;
        end
    end

    assign rise = sig_s_q & ~sig_d_q;
    assign fall = ~sig_s_q & sig_d_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time of a pulse train in clk_in cycles, one valid strobe per period.
// Optional input synchronizer enabled by defining PERIOD_METER_SYNC_EN.
module pulse_period_meter
    import fd_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             ovf,
    output logic             err_short
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);

    logic rise, fall;

    pm_edge_detect u_edge (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    pm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_cap_d = hi_cap_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        err_d    = err_q;

        if (!en) begin
            // Disable beats a coincident rise; captured results stay visible.
            state_d  = ST_IDLE;
            cnt_d    = '0;
            hi_cap_d = '0;
            ovf_d    = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_STALL: begin
                    if (rise) begin
                        state_d  = ST_RUN;
                        cnt_d    = CNT_ONE;
                        hi_cap_d = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_inc;
                    if (rise) begin
                        cnt_d = CNT_ONE;
                        if (cnt_q >= MIN_CNT) begin
                            period_d = cnt_q;
                            high_d   = hi_cap_q;
                            valid_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if (fall) begin
                            hi_cap_d = cnt_q;
                        end
                        if (cnt_q == CNT_SAT) begin
                            ovf_d   = 1'b1;
                            state_d = ST_STALL;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_cap_q <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_cap_q <= hi_cap_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign ovf        = ovf_q;
    assign err_short  = err_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: generator-style pulse trains, overflow, short periods, reset and enable.
module tb_pulse_period_meter;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        en     = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] period_out, high_out;
    logic        valid, ovf, err_short;

    int          pass = 0;
    int          total = 0;
    int          cyc = 0;
    int          vcnt = 0;
    int          vcyc = 0;
    int          pstart = 0;
    logic [15:0] vp = '0;
    logic [15:0] vh = '0;

    pulse_period_meter #(.CNT_W(16), .MIN_PERIOD(3)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .ovf        (ovf),
        .err_short  (err_short)
    );

    always #10 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
        if (valid) begin
            vcnt++;
            vp   = period_out;
            vh   = high_out;
            vcyc = cyc;
        end
    endtask

    task automatic pulse(input int p, input int h);
        pstart = cyc;
        sig_in = 1'b1;
        repeat (h) tick();
        sig_in = 1'b0;
        repeat (p - h) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sig_in = 1'b0;
        repeat (3) tick();
        total++; if (period_out !== 16'd0) $display("FAIL rst_period: got %0d want 0", period_out); else pass++;
        total++; if (high_out !== 16'd0) $display("FAIL rst_high: got %0d want 0", high_out); else pass++;
        total++; if ({valid, ovf, err_short} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {valid, ovf, err_short}); else pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_period();
        int v0;
        v0 = vcnt;
        pulse(1001, 500);
        total++; if (vcnt - v0 !== 0) $display("FAIL first_rise_valid: got %0d want 0", vcnt - v0); else pass++;
        pulse(1001, 500);
        pulse(1001, 500);
        total++; if (vcnt - v0 !== 2) $display("FAIL period_valid_count: got %0d want 2", vcnt - v0); else pass++;
        total++; if (vp !== 16'd1001) $display("FAIL period_value: got %0d want 1001", vp); else pass++;
        total++; if (vh !== 16'd500) $display("FAIL high_value: got %0d want 500", vh); else pass++;
        total++; if (vcyc - pstart !== 2) $display("FAIL valid_latency: got %0d want 2", vcyc - pstart); else pass++;
        total++; if ({ovf, err_short} !== 2'b00) $display("FAIL period_flags: got %b want 00", {ovf, err_short}); else pass++;
    endtask

    task automatic test_modulation();
        int v0;
        v0 = vcnt;
        pulse(1401, 500);
        total++; if (vp !== 16'd1001) $display("FAIL mod_transition: got %0d want 1001", vp); else pass++;
        pulse(1401, 500);
        total++; if (vp !== 16'd1401) $display("FAIL mod_period: got %0d want 1401", vp); else pass++;
        total++; if (vh !== 16'd500) $display("FAIL mod_high: got %0d want 500", vh); else pass++;
        pulse(1001, 500);
        total++; if (vp !== 16'd1401) $display("FAIL mod_back_transition: got %0d want 1401", vp); else pass++;
        pulse(1001, 500);
        total++; if (vp !== 16'd1001) $display("FAIL mod_back_period: got %0d want 1001", vp); else pass++;
        total++; if (vcnt - v0 !== 4) $display("FAIL mod_valid_count: got %0d want 4", vcnt - v0); else pass++;
    endtask

    task automatic test_overflow();
        int v0, n;
        logic in_win;
        v0 = vcnt;
        n = 0;
        sig_in = 1'b0;
        while (!ovf && n < 66000) begin
            tick();
            n++;
        end
        in_win = (n >= 64535) && (n <= 64536);
        total++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else pass++;
        total++; if (in_win !== 1'b1) $display("FAIL ovf_timing: got %0d cycles want 64535..64536", n); else pass++;
        total++; if (vcnt - v0 !== 0) $display("FAIL ovf_no_valid: got %0d want 0", vcnt - v0); else pass++;
        total++; if (period_out !== 16'd1001) $display("FAIL ovf_hold: got %0d want 1001", period_out); else pass++;
        pulse(1001, 500);
        total++; if (vcnt - v0 !== 0) $display("FAIL stall_first_rise: got %0d want 0", vcnt - v0); else pass++;
        pulse(1001, 500);
        total++; if (vcnt - v0 !== 1) $display("FAIL stall_second_rise: got %0d want 1", vcnt - v0); else pass++;
        total++; if ({vp, vh} !== {16'd1001, 16'd500}) $display("FAIL stall_values: got %0d/%0d want 1001/500", vp, vh); else pass++;
        total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else pass++;
        en = 1'b0;
        tick();
        total++; if (ovf !== 1'b0) $display("FAIL ovf_clear_en: got %b want 0", ovf); else pass++;
        total++; if (period_out !== 16'd1001) $display("FAIL en_hold_period: got %0d want 1001", period_out); else pass++;
        en = 1'b1;
        tick();
    endtask

    task automatic test_short();
        int v0;
        v0 = vcnt;
        pulse(1001, 500);
        pulse(2, 1);
        total++; if (err_short !== 1'b0) $display("FAIL short_early: got %b want 0", err_short); else pass++;
        pulse(3, 1);
        total++; if (err_short !== 1'b1) $display("FAIL short_err: got %b want 1", err_short); else pass++;
        total++; if (vcnt - v0 !== 1) $display("FAIL short_no_valid: got %0d want 1", vcnt - v0); else pass++;
        total++; if (period_out !== 16'd1001) $display("FAIL short_hold: got %0d want 1001", period_out); else pass++;
        pulse(1001, 500);
        total++; if ({vp, vh} !== {16'd3, 16'd1}) $display("FAIL min_period_ok: got %0d/%0d want 3/1", vp, vh); else pass++;
        total++; if (err_short !== 1'b1) $display("FAIL short_sticky: got %b want 1", err_short); else pass++;
    endtask

    task automatic test_reset_mid();
        int v0;
        sig_in = 1'b1;
        repeat (500) tick();
        sig_in = 1'b0;
        repeat (200) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({period_out, high_out} !== 32'd0) $display("FAIL midrst_outputs: got %0d/%0d want 0/0", period_out, high_out); else pass++;
        total++; if ({valid, ovf, err_short} !== 3'b000) $display("FAIL midrst_flags: got %b want 000", {valid, ovf, err_short}); else pass++;
        repeat (300) tick();
        v0 = vcnt;
        pulse(1001, 500);
        total++; if (vcnt - v0 !== 0) $display("FAIL midrst_first_rise: got %0d want 0", vcnt - v0); else pass++;
        pulse(1001, 500);
        total++; if (vcnt - v0 !== 1) $display("FAIL midrst_second_rise: got %0d want 1", vcnt - v0); else pass++;
        total++; if ({vp, vh} !== {16'd1001, 16'd500}) $display("FAIL midrst_values: got %0d/%0d want 1001/500", vp, vh); else pass++;
    endtask

    task automatic test_en_rise();
        int v0;
        v0 = vcnt;
        sig_in = 1'b1;
        tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (498) tick();
        sig_in = 1'b0;
        repeat (501) tick();
        total++; if (vcnt - v0 !== 0) $display("FAIL en_rise_no_valid: got %0d want 0", vcnt - v0); else pass++;
        total++; if (period_out !== 16'd1001) $display("FAIL en_rise_hold: got %0d want 1001", period_out); else pass++;
        pulse(1001, 500);
        total++; if (vcnt - v0 !== 0) $display("FAIL reen_first_rise: got %0d want 0", vcnt - v0); else pass++;
        pulse(1001, 500);
        total++; if (vcnt - v0 !== 1) $display("FAIL reen_second_rise: got %0d want 1", vcnt - v0); else pass++;
        total++; if ({vp, vh} !== {16'd1001, 16'd500}) $display("FAIL reen_values: got %0d/%0d want 1001/500", vp, vh); else pass++;
    endtask

    initial begin
        test_reset();
        test_period();
        test_modulation();
        test_overflow();
        test_short();
        test_reset_mid();
        test_en_rise();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
